// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   PC_INIT_DEFAULT : default first fetched PC after reset
//   IF_ID_BUS_W     : width of the IF->ID bus {adef, pc[31:0], inst[31:0]}
//   ADEF_BIT, PC_LSB, INST_LSB : field offsets inside that bus
//   pack_if_id()    : builds one IF->ID bus word from its fields
package if_fetch_buffer_pkg;

    localparam logic [31:0] PC_INIT_DEFAULT = 32'h1c00_0000;
    localparam int unsigned IF_ID_BUS_W     = 65;
    localparam int unsigned ADEF_BIT        = 64;
    localparam int unsigned PC_LSB          = 32;
    localparam int unsigned INST_LSB        = 0;

    function automatic logic [IF_ID_BUS_W-1:0] pack_if_id(
        input logic        adef,
        input logic [31:0] pc,
        input logic [31:0] inst
    );
        logic [IF_ID_BUS_W-1:0] bus;
        bus                  = '0;
        bus[ADEF_BIT]        = adef;
        bus[PC_LSB +: 32]    = pc;
        bus[INST_LSB +: 32]  = inst;
        return bus;
    endfunction

endpackage

// File: rtl/if_fetch_buffer_fifo.sv
// sync_fifo: synchronous FIFO with registered storage.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : empties the FIFO (dominates push/pop)
//   push, push_data : write one entry (accepted if not full, or full and popping)
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry (valid when !empty)
//   count      : number of stored entries
//   full, empty: status flags
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: instruction-fetch stage.
//   PC generator, request/ack instruction-memory interface with up to MAX_OUTST
//   requests in flight, and an IBUF_DEPTH-entry instruction buffer feeding ID.
//   clk, rst          : clock, synchronous active-high reset
//   inst_req/addr     : fetch request and address (current PC)
//   inst_addr_ok      : request accepted this cycle
//   inst_data_ok/rdata: one in-order response this cycle
//   flush/flush_target: WB redirect (wins over br_redirect)
//   br_redirect/br_target : ID taken-branch redirect
//   id_allowin        : ID accepts the buffer head this cycle
//   if_to_id_valid/bus: buffer head {adef, pc, inst} for ID
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter logic [31:0] PC_INIT    = PC_INIT_DEFAULT,
    parameter int unsigned IBUF_DEPTH = 4,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   inst_req,
    output logic [31:0]            inst_addr,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    input  logic [31:0]            inst_rdata,
    input  logic                   flush,
    input  logic [31:0]            flush_target,
    input  logic                   br_redirect,
    input  logic [31:0]            br_target,
    input  logic                   id_allowin,
    output logic                   if_to_id_valid,
    output logic [IF_ID_BUS_W-1:0] if_to_id_bus
);

    localparam int unsigned OW = $clog2(MAX_OUTST) + 1;
    localparam int unsigned BW = $clog2(IBUF_DEPTH) + 1;

    logic [31:0]            pc;
    logic [OW-1:0]          outstanding;
    logic [OW-1:0]          cancel_cnt;
    logic                   adef_stall;

    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   room;
    logic                   addr_hs;
    logic                   live_data;
    logic                   adef_fire;

    logic                   ibuf_push;
    logic                   ibuf_pop;
    logic [IF_ID_BUS_W-1:0] ibuf_din;
    logic [IF_ID_BUS_W-1:0] ibuf_head;
    logic [BW-1:0]          ibuf_count;
    logic                   ibuf_full;
    logic                   ibuf_empty;

    logic [31:0]            tag_pc;
    logic [OW-1:0]          tag_count;
    logic                   tag_full;
    logic                   tag_empty;

    assign redirect    = flush || br_redirect;
    assign redirect_pc = flush ? flush_target : br_target;

    // Every in-flight request (live or cancelled) reserves a buffer slot,
    // so a response can always be accepted.
    assign room = (32'(ibuf_count) + 32'(outstanding)) < IBUF_DEPTH;

    assign inst_req  = !rst && !redirect && !adef_stall && (pc[1:0] == 2'b00)
                       && (32'(outstanding) < MAX_OUTST) && room;
    assign inst_addr = pc;
    assign addr_hs   = inst_req && inst_addr_ok;

    // Cancelled responses carry no tag (the tag queue is cleared on redirect),
    // so only live responses pop it.
    assign live_data = inst_data_ok && (cancel_cnt == '0);

    assign adef_fire = !rst && !redirect && !adef_stall && (pc[1:0] != 2'b00)
                       && (outstanding == '0) && (cancel_cnt == '0) && room;

    assign ibuf_push = !redirect && (live_data || adef_fire);
    assign ibuf_din  = adef_fire ? pack_if_id(1'b1, pc, 32'h0)
                                 : pack_if_id(1'b0, tag_pc, inst_rdata);

    assign if_to_id_valid = !ibuf_empty && !redirect;
    assign if_to_id_bus   = ibuf_empty ? '0 : ibuf_head;
    assign ibuf_pop       = if_to_id_valid && id_allowin;

    sync_fifo #(
        .WIDTH (IF_ID_BUS_W),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (ibuf_push),
        .push_data (ibuf_din),
        .pop       (ibuf_pop),
        .head      (ibuf_head),
        .count     (ibuf_count),
        .full      (ibuf_full),
        .empty     (ibuf_empty)
    );

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTST)
    ) u_pc_tag (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (addr_hs),
        .push_data (pc),
        .pop       (live_data),
        .head      (tag_pc),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= PC_INIT;
            outstanding <= '0;
            cancel_cnt  <= '0;
            adef_stall  <= 1'b0;
        end else begin
            outstanding <= outstanding + OW'(addr_hs) - OW'(inst_data_ok);
            if (redirect) begin
                pc         <= redirect_pc;
                // Everything still pending after this edge becomes cancelled;
                // this already covers responses that were cancelled earlier.
                cancel_cnt <= outstanding + OW'(addr_hs) - OW'(inst_data_ok);
                adef_stall <= 1'b0;
            end else begin
                if (addr_hs) begin
                    pc <= pc + 32'd4;
                end
                if (inst_data_ok && (cancel_cnt != '0)) begin
                    cancel_cnt <= cancel_cnt - OW'(1);
                end
                if (adef_fire) begin
                    adef_stall <= 1'b1;
                end
            end
        end
    end

    ap_no_ibuf_overflow: assert property (@(posedge clk) disable iff (rst)
        !(ibuf_push && ibuf_full && !ibuf_pop));
    ap_no_spurious_data: assert property (@(posedge clk) disable iff (rst)
        !(inst_data_ok && (outstanding == '0)));
    ap_cancel_bound: assert property (@(posedge clk) disable iff (rst)
        32'(cancel_cnt) <= MAX_OUTST);
    ap_tag_balance: assert property (@(posedge clk) disable iff (rst)
        (32'(tag_count) + 32'(cancel_cnt)) == 32'(outstanding));
    ap_tag_push_room: assert property (@(posedge clk) disable iff (rst)
        !(addr_hs && tag_full));
    ap_tag_pop_avail: assert property (@(posedge clk) disable iff (rst)
        !(live_data && tag_empty));

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;

    localparam logic [31:0] P     = 32'h1c00_0000;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        flush;
    logic [31:0] flush_target;
    logic        br_redirect;
    logic [31:0] br_target;
    logic        id_allowin;
    logic        if_to_id_valid;
    logic [64:0] if_to_id_bus;

    always #5 clk = ~clk;

    if_fetch_buffer #(
        .PC_INIT    (P),
        .IBUF_DEPTH (DEPTH),
        .MAX_OUTST  (MAXO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .flush          (flush),
        .flush_target   (flush_target),
        .br_redirect    (br_redirect),
        .br_target      (br_target),
        .id_allowin     (id_allowin),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_bus   (if_to_id_bus)
    );

    // Reference model: list of pending requests (each possibly cancelled),
    // a queue of buffered IF->ID words, the fetch PC and the ADEF stall flag.
    typedef struct {
        logic [31:0] pc;
        bit          cancelled;
        int unsigned ready;
    } req_t;

    req_t        pend[$];
    logic [64:0] mbuf[$];
    logic [31:0] mpc;
    bit          mstall;
    int unsigned cyc;
    int unsigned lat_max;
    int unsigned checks;
    int unsigned passes;
    logic [31:0] id_seen[$];
    int unsigned hs_seen;

    typedef struct {
        bit          f;
        bit          b;
        logic [31:0] ft;
        logic [31:0] bt;
        bit          dok;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        bit          e_adef;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tab [23];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[31:16]};
    endfunction

    function automatic logic [64:0] ent(input bit adef, input logic [31:0] pc);
        return adef ? {1'b1, pc, 32'h0} : {1'b0, pc, memf(pc)};
    endfunction

    function automatic vec_t V(input bit f, input bit b, input logic [31:0] ft,
                               input logic [31:0] bt, input bit dok, input bit ereq,
                               input logic [31:0] eaddr, input bit evalid,
                               input bit eadef, input logic [31:0] epc);
        vec_t v;
        v.f = f; v.b = b; v.ft = ft; v.bt = bt; v.dok = dok;
        v.e_req = ereq; v.e_addr = eaddr; v.e_valid = evalid;
        v.e_adef = eadef; v.e_pc = epc;
        return v;
    endfunction

    function automatic bit auto_dok();
        return (pend.size() != 0) && (pend[0].ready <= cyc);
    endfunction

    function automatic logic [31:0] rand_target();
        int unsigned r;
        logic [31:0] t;
        r = $urandom_range(19);
        if (r == 0) return 32'hffff_fff8;
        t = P + 32'($urandom_range(255)) * 32'd4;
        if (r < 4) t = t + 32'($urandom_range(3, 1));
        return t;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Called at posedge+1; returns at the sampling point (negedge).
    task automatic drive(input bit f, input bit b, input logic [31:0] ft, input logic [31:0] bt,
                         input bit allow, input bit aok, input bit dok);
        flush        = f;
        br_redirect  = b;
        flush_target = ft;
        br_target    = bt;
        id_allowin   = allow;
        inst_addr_ok = aok;
        inst_data_ok = dok && (pend.size() != 0);
        inst_rdata   = inst_data_ok ? memf(pend[0].pc) : $urandom;
        #4;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step();
        bit          redir;
        bit          exp_req;
        bit          exp_valid;
        bit          adef;
        req_t        r;
        logic [64:0] tmp;
        redir     = flush || br_redirect;
        exp_req   = !redir && !mstall && (mpc[1:0] == 2'b00) && (pend.size() < MAXO)
                    && (mbuf.size() + pend.size() < DEPTH);
        exp_valid = (mbuf.size() != 0) && !redir;
        adef      = !redir && !mstall && (mpc[1:0] != 2'b00) && (pend.size() == 0)
                    && (mbuf.size() < DEPTH);
        check("inst_req", inst_req, exp_req);
        if (exp_req) check("inst_addr", inst_addr, mpc);
        check("if_to_id_valid", if_to_id_valid, exp_valid);
        if (exp_valid) check("if_to_id_bus", if_to_id_bus, mbuf[0]);
        if (if_to_id_valid && id_allowin) id_seen.push_back(if_to_id_bus[63:32]);
        if (inst_req && inst_addr_ok) hs_seen++;

        if (exp_valid && id_allowin) tmp = mbuf.pop_front();
        if (inst_data_ok) begin
            r = pend.pop_front();
            if (!r.cancelled && !redir) mbuf.push_back(ent(1'b0, r.pc));
        end
        if (adef) begin
            mbuf.push_back(ent(1'b1, mpc));
            mstall = 1'b1;
        end
        if (exp_req && inst_addr_ok) begin
            r.pc        = mpc;
            r.cancelled = 1'b0;
            r.ready     = cyc + 1 + $urandom_range(lat_max);
            pend.push_back(r);
            mpc = mpc + 32'd4;
        end
        if (redir) begin
            mbuf.delete();
            foreach (pend[i]) pend[i].cancelled = 1'b1;
            mpc    = flush ? flush_target : br_target;
            mstall = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        flush        = 1'b0;
        br_redirect  = 1'b0;
        flush_target = '0;
        br_target    = '0;
        id_allowin   = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        #4;
        check("rst_req_first", inst_req, 1'b0);
        advance();
        #4;
        check("rst_req", inst_req, 1'b0);
        check("rst_valid", if_to_id_valid, 1'b0);
        check("rst_bus", if_to_id_bus, 65'h0);
        advance();
        rst = 1'b0;
        pend.delete();
        mbuf.delete();
        mpc    = P;
        mstall = 1'b0;
    endtask

    initial begin
        bit          f;
        bit          b;
        int unsigned rnd;

        checks  = 0;
        passes  = 0;
        cyc     = 0;
        lat_max = 0;
        hs_seen = 0;

        // zero-wait fetch, branch with two in flight, flush+branch together
        // over a live response, misaligned flush (ADEF), resume
        tab[0]  = V(0, 0, 0, 0, 0,          1, P + 32'h000, 0, 0, 0);
        tab[1]  = V(0, 0, 0, 0, 1,          1, P + 32'h004, 0, 0, 0);
        tab[2]  = V(0, 0, 0, 0, 1,          1, P + 32'h008, 1, 0, P + 32'h000);
        tab[3]  = V(0, 0, 0, 0, 1,          1, P + 32'h00c, 1, 0, P + 32'h004);
        tab[4]  = V(0, 0, 0, 0, 1,          1, P + 32'h010, 1, 0, P + 32'h008);
        tab[5]  = V(0, 0, 0, 0, 0,          1, P + 32'h014, 1, 0, P + 32'h00c);
        tab[6]  = V(0, 1, 0, P + 32'h100, 0, 0, 0,          0, 0, 0);
        tab[7]  = V(0, 0, 0, 0, 1,          0, 0,           0, 0, 0);
        tab[8]  = V(0, 0, 0, 0, 1,          1, P + 32'h100, 0, 0, 0);
        tab[9]  = V(0, 0, 0, 0, 1,          1, P + 32'h104, 0, 0, 0);
        tab[10] = V(0, 0, 0, 0, 0,          1, P + 32'h108, 1, 0, P + 32'h100);
        tab[11] = V(1, 1, P + 32'h300, P + 32'h400, 1, 0, 0, 0, 0, 0);
        tab[12] = V(0, 0, 0, 0, 1,          1, P + 32'h300, 0, 0, 0);
        tab[13] = V(0, 0, 0, 0, 1,          1, P + 32'h304, 0, 0, 0);
        tab[14] = V(0, 0, 0, 0, 1,          1, P + 32'h308, 1, 0, P + 32'h300);
        tab[15] = V(1, 0, P + 32'h102, 0, 1, 0, 0,          0, 0, 0);
        tab[16] = V(0, 0, 0, 0, 0,          0, 0,           0, 0, 0);
        tab[17] = V(0, 0, 0, 0, 0,          0, 0,           1, 1, P + 32'h102);
        tab[18] = V(0, 0, 0, 0, 0,          0, 0,           0, 0, 0);
        tab[19] = V(1, 0, P + 32'h200, 0, 0, 0, 0,          0, 0, 0);
        tab[20] = V(0, 0, 0, 0, 0,          1, P + 32'h200, 0, 0, 0);
        tab[21] = V(0, 0, 0, 0, 1,          1, P + 32'h204, 0, 0, 0);
        tab[22] = V(0, 0, 0, 0, 1,          1, P + 32'h208, 1, 0, P + 32'h200);

        do_reset();
        for (int unsigned i = 0; i < 23; i++) begin
            drive(tab[i].f, tab[i].b, tab[i].ft, tab[i].bt, 1'b1, 1'b1, tab[i].dok);
            check($sformatf("tab%0d_req", i), inst_req, tab[i].e_req);
            if (tab[i].e_req) check($sformatf("tab%0d_addr", i), inst_addr, tab[i].e_addr);
            check($sformatf("tab%0d_valid", i), if_to_id_valid, tab[i].e_valid);
            if (tab[i].e_valid)
                check($sformatf("tab%0d_bus", i), if_to_id_bus, ent(tab[i].e_adef, tab[i].e_pc));
            model_step();
            advance();
        end

        // ID stall: buffer fills to exactly DEPTH, head held, then in-order drain
        do_reset();
        lat_max = 0;
        hs_seen = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, auto_dok());
            if (i >= 7) check("stall_head", if_to_id_bus, ent(1'b0, P));
            model_step();
            advance();
        end
        check("stall_hs_count", hs_seen, DEPTH);
        id_seen.delete();
        for (int unsigned i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, auto_dok());
            model_step();
            advance();
        end
        check("drain_count", id_seen.size() >= 8, 1'b1);
        for (int unsigned i = 0; i < 8 && i < id_seen.size(); i++)
            check("drain_pc", id_seen[i], P + 32'(4 * i));

        // random latency, stalls and redirects, with a mid-stream reset
        do_reset();
        lat_max = 5;
        id_seen.delete();
        for (int unsigned i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            rnd = $urandom_range(99);
            f   = (rnd < 2);
            b   = (rnd < 1) || (rnd >= 2 && rnd < 5);
            drive(f, b, rand_target(), rand_target(), $urandom_range(3) != 0,
                  $urandom_range(9) < 7, auto_dok() && ($urandom_range(3) != 0));
            model_step();
            advance();
        end
        check("random_delivered", id_seen.size() > 200, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
